// File: rtl/exmem_pkg.sv
// Shared widths, MEM/WB control bit positions and buffer state encoding for the EX/MEM skid register.
package exmem_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W_DEF = 4;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/exmem_entry.sv
// One buffer slot: payload plus valid bit. Load takes effect on the next edge.
// No backpressure of its own; clear wins over load, rst wins over both.
module exmem_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with a skid slot: 1-cycle latency, 1 transfer/cycle.
// in_ready is registered (!skid valid); EXMEM_FWD_EN adds the EX/MEM forwarding outputs.
module exmem_skid_reg
  import exmem_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_aluresult,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_aluresult,
  output logic [XLEN-1:0]   out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef EXMEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
`endif
);

  localparam int PW = 2*XLEN + REG_AW + CTRL_W;

  state_e          state_q, state_nx;
  logic            accept, pop;
  logic            main_load, main_clr, main_sel_skid, skid_load, skid_clr;
  logic            main_vld, skid_vld;
  logic [PW-1:0]   in_dat, main_d, main_dat, skid_dat;

  assign in_dat   = {in_aluresult, in_store_data, in_rd, in_ctrl};
  assign main_d   = main_sel_skid ? skid_dat : in_dat;
  assign in_ready = !skid_vld;
  // A slot being reset must not complete an output handshake this cycle.
  assign out_valid = main_vld && !rst;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_aluresult, out_store_data, out_rd, out_ctrl} = main_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_nx;
      occupancy <= occ_of(state_nx);
    end
  end

  always_comb begin
    state_nx      = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_nx  = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_nx  = FULL;
          end else if (pop) begin
            main_clr = 1'b1;
            state_nx = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen; skid shifts forward.
          if (pop) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
            state_nx      = ONE;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  exmem_entry #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .vld   (main_vld),
    .q     (main_dat)
  );

  exmem_entry #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_dat),
    .vld   (skid_vld),
    .q     (skid_dat)
  );

`ifdef EXMEM_FWD_EN
  assign fwd_valid = out_valid && out_ctrl[CTRL_REG_WRITE] && !out_ctrl[CTRL_MEM_READ]
                     && (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_aluresult;
`endif

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Randomized scoreboard bench for exmem_skid_reg: a FIFO-of-depth-2 queue model plus directed scenarios.
module tb_exmem_skid_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;
  localparam int PW     = 2*XLEN + REG_AW + CTRL_W;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [XLEN-1:0]   in_aluresult, in_store_data, out_aluresult, out_store_data;
  logic [REG_AW-1:0] in_rd, out_rd;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
`ifdef EXMEM_FWD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [XLEN-1:0]   fwd_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  int            mdl_n;

  exmem_skid_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_aluresult   (in_aluresult),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_aluresult  (out_aluresult),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_ctrl       (out_ctrl),
    .occupancy      (occupancy)
`ifdef EXMEM_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an in-order queue holding at most two items.
  always @(posedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      mdl_n = exp_q.size();
      if (out_ready && mdl_n > 0) void'(exp_q.pop_front());
      if (in_valid && mdl_n < 2)
        exp_q.push_back({in_aluresult, in_store_data, in_rd, in_ctrl});
    end
  end

  // Monitor: compares what the DUT presents against the head of the model queue.
  always @(negedge clk) begin
    logic          ev;
    logic [PW-1:0] h;
    ev = (exp_q.size() > 0) && !rst;
    h  = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("occupancy", 128'(occupancy), 128'(exp_q.size()));
    chk("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(ev));
    if (ev)
      chk("out_payload", 128'({out_aluresult, out_store_data, out_rd, out_ctrl}), 128'(h));
`ifdef EXMEM_FWD_EN
    chk("fwd_valid_mon", 128'(fwd_valid),
        128'(ev && h[0] && !h[1] && (h[CTRL_W +: REG_AW] != '0)));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [XLEN-1:0] alu, input logic [REG_AW-1:0] rd,
                      input logic [CTRL_W-1:0] ctrl);
    in_valid      = 1'b1;
    in_aluresult  = alu;
    in_store_data = ~alu;
    in_rd         = rd;
    in_ctrl       = ctrl;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_occupancy"}, 128'(occupancy), 128'(0));
    chk({tag, "_payload"}, 128'({out_aluresult, out_store_data, out_rd, out_ctrl}), 128'(0));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_aluresult = '0; in_store_data = '0; in_rd = '0; in_ctrl = '0;
    step(); step();
    rst = 1'b0;
    chk_reset_values("reset");

    // Single beat: visible one cycle after acceptance.
    out_ready = 1'b1;
    beat(32'h0000_1234, 5'd3, 4'b0001);
    chk("first_valid", 128'(out_valid), 128'(1));
    chk("first_alu", 128'(out_aluresult), 128'(32'h1234));
    chk("first_rd", 128'(out_rd), 128'(3));
    chk("first_occ", 128'(occupancy), 128'(1));
    step();

    // Backpressure fills both slots, then drains in order.
    out_ready = 1'b0;
    beat(32'h11, 5'd1, 4'b0001);
    beat(32'h22, 5'd2, 4'b0001);
    chk("full_occ", 128'(occupancy), 128'(2));
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_head", 128'(out_aluresult), 128'(32'h11));
    step();
    chk("full_head_held", 128'(out_aluresult), 128'(32'h11));
    out_ready = 1'b1;
    step();
    chk("drain_b", 128'(out_aluresult), 128'(32'h22));
    chk("drain_b_valid", 128'(out_valid), 128'(1));
    step();
    chk("drain_empty", 128'(out_valid), 128'(0));

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      beat(XLEN'(i), 5'd4, 4'b0001);
      chk("stream_alu", 128'(out_aluresult), 128'(i));
      chk("stream_in_ready", 128'(in_ready), 128'(1));
    end
    step();

    // Flush while full drops everything, including the offered input.
    out_ready = 1'b0;
    beat(32'h33, 5'd5, 4'b0000);
    beat(32'h44, 5'd6, 4'b0000);
    flush = 1'b1; in_valid = 1'b1; in_aluresult = 32'h99;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    step();
    chk("flush_dropped", 128'(occupancy), 128'(0));

`ifdef EXMEM_FWD_EN
    beat(32'hA5A5, 5'd0, 4'b0001);
    chk("fwd_rd0", 128'(fwd_valid), 128'(0));
    flush = 1'b1; step(); flush = 1'b0;
    beat(32'hBEEF, 5'd7, 4'b0001);
    chk("fwd_rd7", 128'(fwd_valid), 128'(1));
    chk("fwd_data", 128'(fwd_data), 128'(32'hBEEF));
    chk("fwd_rd", 128'(fwd_rd), 128'(7));
    flush = 1'b1; step(); flush = 1'b0;
    beat(32'hCAFE, 5'd7, 4'b0011);
    chk("fwd_load", 128'(fwd_valid), 128'(0));
    flush = 1'b1; step(); flush = 1'b0;
`endif

    // Reset beats flush and accept while full.
    beat(32'h55, 5'd8, 4'b1111);
    beat(32'h66, 5'd9, 4'b1111);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_aluresult = 32'h77;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk_reset_values("rst_full");

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      in_valid      = ($urandom % 4) != 0;
      in_aluresult  = $urandom;
      in_store_data = $urandom;
      in_rd         = REG_AW'($urandom);
      in_ctrl       = CTRL_W'($urandom);
      out_ready     = ($urandom % 3) != 0;
      flush         = ($urandom % 40) == 0;
      rst           = ($urandom % 150) == 0;
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmem_skid_reg.md
EXMEM_SKID_REG -- requirements
Module: exmem_skid_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, ALU result and store-data width.
REQ-002 SHALL have parameter REG_AW, default 5, destination register address width.
REQ-003 SHALL have parameter CTRL_W, default 4, MEM/WB control bundle width (bit0 reg_write, bit1 mem_read, bit2 mem_write, bit3 mem_to_reg).
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1 rising-edge clock; rst in 1 sync active-high reset.
REQ-005 SHALL have ports: flush in 1 kill all held entries; in_valid in 1; in_ready out 1; in_aluresult in XLEN; in_store_data in XLEN; in_rd in REG_AW; in_ctrl in CTRL_W.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; out_aluresult out XLEN; out_store_data out XLEN; out_rd out REG_AW; out_ctrl out CTRL_W; occupancy out 2 (entries held, 0..2).

Function
REQ-007 SHALL act as a 2-entry in-order buffer: a main (output) entry and a skid entry.
REQ-008 SHALL accept input when in_valid && in_ready at the clock edge, and present output when out_valid && out_ready at the clock edge.
REQ-009 SHALL drive in_ready = !skid_valid from a register, with no combinational path from out_ready.
REQ-010 SHALL have states EMPTY, ONE, FULL. EMPTY->ONE on accept. ONE->FULL on accept without pop. ONE->EMPTY on pop without accept. ONE stays ONE on accept plus pop. FULL->ONE on pop (no accept is possible in FULL).
REQ-011 SHALL set latency 1 cycle from accept in EMPTY to out_valid=1 with the accepted payload; sustained throughput SHALL be 1 transfer per cycle.
REQ-012 SHALL, on pop in FULL, move the skid entry into the main entry in the same edge; on accept-plus-pop in ONE, load the input directly into the main entry.
REQ-013 SHALL hold out_* payload stable while out_valid && !out_ready.
REQ-014 SHALL, on flush=1, clear both valid bits and drop any same-cycle input transfer; occupancy becomes 0 the next cycle. flush SHALL override accept and pop.
REQ-015 SHALL give rst priority over flush.
REQ-016 SHALL drive occupancy = number of valid entries, registered.

Reset
REQ-017 SHALL, on rst, set out_valid=0, in_ready=1, occupancy=0, all out_* payload=0, skid entry cleared, state EMPTY.
REQ-018 SHALL, on rst asserted mid-transfer, discard held and incoming data with no output handshake completing that cycle.

Configuration
REQ-019 SHALL, when EXMEM_FWD_EN is defined, add outputs fwd_valid out 1, fwd_rd out REG_AW, fwd_data out XLEN: fwd_valid = out_valid && ctrl.reg_write && !ctrl.mem_read && out_rd!=0, with fwd_data=out_aluresult and fwd_rd=out_rd, all combinational from the main entry.
REQ-020 SHALL, without EXMEM_FWD_EN, omit these ports and add no logic.

Structure
REQ-021 SHALL place the CTRL bit-index constants, the default widths and the EMPTY/ONE/FULL state enum in shared package exmem_pkg.
REQ-022 SHALL hold each entry in one instantiated sub-module exmem_entry, a payload+valid register with load and clear inputs, instantiated twice.

Verification
REQ-023 SHALL check: rst, then in_valid=1, aluresult=0x0000_1234, rd=3, out_ready=1 -> next cycle out_valid=1, out_aluresult=0x1234, occupancy=1.
REQ-024 SHALL check: out_ready=0 with 2 accepts (A=0x11, B=0x22) -> occupancy=2, in_ready=0, out=A held; then out_ready=1 -> out=A then B over consecutive cycles.
REQ-025 SHALL check: streaming 8 values 1..8 with out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready stays 1.
REQ-026 SHALL check: FULL plus flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, the input is dropped.
REQ-027 SHALL check, with EXMEM_FWD_EN: ctrl=4'b0001, rd=0 -> fwd_valid=0; rd=7 -> fwd_valid=1, fwd_data=out_aluresult; ctrl=4'b0011 -> fwd_valid=0.
REQ-028 SHALL check: rst=1 coincident with flush and accept while FULL -> all REQ-017 values on the next cycle.
